// File: rtl/i2c_master_nbyte.sv
// i2c_master_nbyte
// ----------------
// Single-transaction I2C master: START, 7-bit address + R/W, DATA_BYTES data
// bytes (write or read), STOP. SCL is derived from CLK; every bit period is
// split into four quarters of CLK_DIV cycles (SCL low in Q0-Q1, high in Q2-Q3).
//
// Ports
//   CLK        system clock, all logic on the rising edge
//   RESET      synchronous active-high reset
//   START_STB  start request, honoured only while idle
//   RNW        1 = read, 0 = write (latched with START_STB)
//   I2C_ADDR   7-bit slave address (latched with START_STB)
//   WR_DATA    write payload, first byte in the most significant byte
//   SDA_IN     SDA line as seen by the master
//   SDA_OUT    value driven on SDA when SDA_OE = 1
//   SDA_OE     1 = master drives SDA, 0 = released to the slave
//   SCL        I2C clock
//   RD_DATA    read payload, first byte in the most significant byte
//   BUSY       transaction in progress
//   DONE       one-cycle pulse when the transaction ends
//   NACK_ERR   last transaction was aborted by a NACK
module i2c_master_nbyte #(
    parameter int DATA_BYTES = 2,
    parameter int CLK_DIV    = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    START_STB,
    input  logic                    RNW,
    input  logic [6:0]              I2C_ADDR,
    input  logic [8*DATA_BYTES-1:0] WR_DATA,
    input  logic                    SDA_IN,
    output logic                    SDA_OUT,
    output logic                    SDA_OE,
    output logic                    SCL,
    output logic [8*DATA_BYTES-1:0] RD_DATA,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    NACK_ERR
);

    localparam int NB = 8 * DATA_BYTES;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR_BYTE,
        S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_STOP
    } state_t;

    state_t          state_reg, state_next;
    logic [DW-1:0]   div_cnt_reg;
    logic [1:0]      quarter_reg;
    logic [2:0]      bit_cnt_reg;
    logic [BW-1:0]   byte_cnt_reg;
    logic [6:0]      addr_reg;
    logic            rnw_reg;
    logic [NB-1:0]   wr_sreg_reg;
    logic [NB-1:0]   rx_sreg_reg;
    logic [NB-1:0]   rd_data_reg;
    logic            ack_reg;
    logic            nack_err_reg;
    logic            done_reg;

    logic            quarter_end, sample_pt, bit_end, last_byte;
    logic [7:0]      tx_byte;

    assign quarter_end = (div_cnt_reg == DW'(CLK_DIV - 1));
    assign sample_pt   = quarter_end && (quarter_reg == 2'd2);
    assign bit_end     = quarter_end && (quarter_reg == 2'd3);
    assign last_byte   = (byte_cnt_reg == BW'(DATA_BYTES - 1));

    // The current write byte always sits in the top byte of the shift register.
    assign tx_byte = (state_reg == S_ADDR) ? {addr_reg, rnw_reg} : wr_sreg_reg[NB-1 -: 8];

    // Next-state logic; ACK decisions use the value sampled in Q2 of the same bit.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:     if (START_STB) state_next = S_START;
            S_START:    if (bit_end) state_next = S_ADDR;
            S_ADDR:     if (bit_end && bit_cnt_reg == 3'd7) state_next = S_ADDR_ACK;
            S_ADDR_ACK: if (bit_end) state_next = ack_reg ? S_STOP : (rnw_reg ? S_RD_BYTE : S_WR_BYTE);
            S_WR_BYTE:  if (bit_end && bit_cnt_reg == 3'd7) state_next = S_WR_ACK;
            S_WR_ACK:   if (bit_end) state_next = (ack_reg || last_byte) ? S_STOP : S_WR_BYTE;
            S_RD_BYTE:  if (bit_end && bit_cnt_reg == 3'd7) state_next = S_RD_ACK;
            S_RD_ACK:   if (bit_end) state_next = last_byte ? S_STOP : S_RD_BYTE;
            S_STOP:     if (bit_end) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Bus outputs depend only on registered state, so SDA moves at Q0 starts
    // except for the deliberate START/STOP edges while SCL is high.
    always_comb begin
        SCL     = 1'b1;
        SDA_OUT = 1'b1;
        SDA_OE  = 1'b1;
        case (state_reg)
            S_START: SDA_OUT = ~quarter_reg[1];
            S_ADDR, S_WR_BYTE: begin
                SCL     = quarter_reg[1];
                SDA_OUT = tx_byte[3'd7 - bit_cnt_reg];
            end
            S_ADDR_ACK, S_WR_ACK, S_RD_BYTE: begin
                SCL    = quarter_reg[1];
                SDA_OE = 1'b0;
            end
            S_RD_ACK: begin
                SCL     = quarter_reg[1];
                SDA_OUT = last_byte;           // ACK all but the final byte
            end
            S_STOP: begin
                SCL     = quarter_reg[1];
                SDA_OUT = (quarter_reg == 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg    <= S_IDLE;
            div_cnt_reg  <= '0;
            quarter_reg  <= '0;
            bit_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
            addr_reg     <= '0;
            rnw_reg      <= 1'b0;
            wr_sreg_reg  <= '0;
            rx_sreg_reg  <= '0;
            rd_data_reg  <= '0;
            ack_reg      <= 1'b0;
            nack_err_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            if (state_reg == S_IDLE) begin
                div_cnt_reg  <= '0;
                quarter_reg  <= '0;
                bit_cnt_reg  <= '0;
                byte_cnt_reg <= '0;
                if (START_STB) begin
                    addr_reg     <= I2C_ADDR;
                    rnw_reg      <= RNW;
                    wr_sreg_reg  <= WR_DATA;
                    rx_sreg_reg  <= '0;
                    nack_err_reg <= 1'b0;
                end
            end else begin
                if (quarter_end) begin
                    div_cnt_reg <= '0;
                    quarter_reg <= quarter_reg + 2'd1;
                end else begin
                    div_cnt_reg <= div_cnt_reg + DW'(1);
                end
                if (sample_pt) begin
                    ack_reg <= SDA_IN;
                    if (state_reg == S_RD_BYTE)
                        rx_sreg_reg <= {rx_sreg_reg[NB-2:0], SDA_IN};
                end
                if (bit_end) begin
                    case (state_reg)
                        S_ADDR, S_WR_BYTE, S_RD_BYTE: bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        S_ADDR_ACK: if (ack_reg) nack_err_reg <= 1'b1;
                        S_WR_ACK: begin
                            if (ack_reg) begin
                                nack_err_reg <= 1'b1;
                            end else if (!last_byte) begin
                                byte_cnt_reg <= byte_cnt_reg + BW'(1);
                                wr_sreg_reg  <= wr_sreg_reg << 8;
                            end
                        end
                        S_RD_ACK: if (!last_byte) byte_cnt_reg <= byte_cnt_reg + BW'(1);
                        S_STOP: begin
                            done_reg <= 1'b1;
                            if (rnw_reg && !nack_err_reg) rd_data_reg <= rx_sreg_reg;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign BUSY     = (state_reg != S_IDLE);
    assign DONE     = done_reg;
    assign NACK_ERR = nack_err_reg;
    assign RD_DATA  = rd_data_reg;

endmodule

// File: tb/tb_i2c_master_nbyte.sv
// Directed bench for i2c_master_nbyte: a default build (2 bytes, CLK_DIV=4)
// and a 4-byte CLK_DIV=1 build, each on its own open-drain bus with a simple
// behavioural slave that records address/data bytes and master ACKs.
module tb_i2c_master_nbyte;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_stb, a_rnw;
    logic [6:0]  a_addr;
    logic [15:0] a_wdata, a_rdata;
    logic        a_sda_out, a_sda_oe, a_scl, a_busy, a_done, a_nack;

    logic        b_stb, b_rnw;
    logic [6:0]  b_addr;
    logic [31:0] b_wdata, b_rdata;
    logic        b_sda_out, b_sda_oe, b_scl, b_busy, b_done, b_nack;

    bit   [1:0]  pull = 2'b00;
    logic [1:0]  sda_v, scl_v, busy_v, done_v;

    assign sda_v[0] = (a_sda_oe ? a_sda_out : 1'b1) & ~pull[0];
    assign sda_v[1] = (b_sda_oe ? b_sda_out : 1'b1) & ~pull[1];
    assign scl_v    = {b_scl, a_scl};
    assign busy_v   = {b_busy, a_busy};
    assign done_v   = {b_done, a_done};

    i2c_master_nbyte #(.DATA_BYTES(2), .CLK_DIV(4)) dut_a (
        .CLK(clk), .RESET(rst), .START_STB(a_stb), .RNW(a_rnw), .I2C_ADDR(a_addr),
        .WR_DATA(a_wdata), .SDA_IN(sda_v[0]), .SDA_OUT(a_sda_out), .SDA_OE(a_sda_oe),
        .SCL(a_scl), .RD_DATA(a_rdata), .BUSY(a_busy), .DONE(a_done), .NACK_ERR(a_nack)
    );

    i2c_master_nbyte #(.DATA_BYTES(4), .CLK_DIV(1)) dut_b (
        .CLK(clk), .RESET(rst), .START_STB(b_stb), .RNW(b_rnw), .I2C_ADDR(b_addr),
        .WR_DATA(b_wdata), .SDA_IN(sda_v[1]), .SDA_OUT(b_sda_out), .SDA_OE(b_sda_oe),
        .SCL(b_scl), .RD_DATA(b_rdata), .BUSY(b_busy), .DONE(b_done), .NACK_ERR(b_nack)
    );

    // slave configuration (written by the stimulus only)
    logic [6:0]  slv_addr [2];
    bit   [1:0]  present;
    int          nack_byte [2];
    logic [7:0]  rds [2][4];
    int          nbytes [2] = '{2, 4};

    // slave / monitor state (written by the monitor only)
    bit   [1:0]  active, scl_d, sda_d, busy_d;
    int          nbit [2], got_n [2], starts [2], scl_rises [2];
    int          busy_cyc [2], done_cyc [2], done_cnt [2];
    logic [7:0]  shreg [2], addr_seen [2];
    logic [7:0]  got [2][4];
    logic [3:0]  mack [2];
    int          cyc, slot_t, dbyte_t;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        scl_d  <= scl_v;
        sda_d  <= sda_v;
        busy_d <= busy_v;
        for (int u = 0; u < 2; u++) begin
            if (scl_v[u] && !scl_d[u]) scl_rises[u] <= scl_rises[u] + 1;
            if (busy_v[u] && !busy_d[u]) busy_cyc[u] <= cyc;
            if (done_v[u]) begin
                done_cyc[u] <= cyc;
                done_cnt[u] <= done_cnt[u] + 1;
            end
            if (scl_v[u] && scl_d[u] && sda_d[u] && !sda_v[u]) begin
                active[u] <= 1'b1;
                nbit[u]   <= 0;
                got_n[u]  <= 0;
                pull[u]   <= 1'b0;
                mack[u]   <= 4'hF;
                starts[u] <= starts[u] + 1;
            end else if (scl_v[u] && scl_d[u] && !sda_d[u] && sda_v[u]) begin
                active[u] <= 1'b0;
                pull[u]   <= 1'b0;
            end else if (active[u] && scl_v[u] && !scl_d[u]) begin
                nbit[u] <= nbit[u] + 1;
                slot_t = nbit[u] % 9;
                if (slot_t < 8) shreg[u] <= {shreg[u][6:0], sda_v[u]};
                if (slot_t == 7) begin
                    if (nbit[u] == 7)
                        addr_seen[u] <= {shreg[u][6:0], sda_v[u]};
                    else if (!addr_seen[u][0] && got_n[u] < 4) begin
                        got[u][got_n[u]] <= {shreg[u][6:0], sda_v[u]};
                        got_n[u] <= got_n[u] + 1;
                    end
                end
                if (slot_t == 8 && nbit[u] > 8 && addr_seen[u][0] && (nbit[u] - 17) / 9 < 4)
                    mack[u][(nbit[u] - 17) / 9] <= sda_v[u];
            end else if (active[u] && !scl_v[u] && scl_d[u]) begin
                slot_t  = nbit[u] % 9;
                dbyte_t = (nbit[u] - 9) / 9;
                if (nbit[u] == 8)
                    pull[u] <= present[u] && (addr_seen[u][7:1] == slv_addr[u]);
                else if (nbit[u] < 9)
                    pull[u] <= 1'b0;
                else if (!addr_seen[u][0])
                    pull[u] <= (slot_t == 8) && (dbyte_t != nack_byte[u]);
                else if (slot_t == 8 || dbyte_t >= nbytes[u])
                    pull[u] <= 1'b0;
                else
                    pull[u] <= ~rds[u][dbyte_t][7 - slot_t];
            end
        end
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_vec++;
        if (got_v !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    task automatic start_a(input logic [6:0] addr, input logic rnw, input logic [15:0] wdata);
        @(negedge clk);
        a_addr  = addr;
        a_rnw   = rnw;
        a_wdata = wdata;
        a_stb   = 1'b1;
        @(negedge clk);
        a_stb   = 1'b0;
    endtask

    // Returns at the negedge inside the DONE cycle, or after the budget expires.
    task automatic wait_done(input int u, input string tag);
        int n = 0;
        while (!done_v[u] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 64'(done_v[u]), 64'd1);
    endtask

    int base_r, base_d, base_s;

    initial begin
        rst = 1'b1;
        a_stb = 1'b0; a_rnw = 1'b0; a_addr = '0; a_wdata = '0;
        b_stb = 1'b0; b_rnw = 1'b0; b_addr = '0; b_wdata = '0;
        slv_addr[0] = 7'h1A; slv_addr[1] = 7'h50;
        present = 2'b11;
        nack_byte[0] = -1; nack_byte[1] = -1;
        rds[0][0] = 8'hEE; rds[0][1] = 8'hED; rds[0][2] = 8'h00; rds[0][3] = 8'h00;
        rds[1][0] = 8'h00; rds[1][1] = 8'h00; rds[1][2] = 8'h00; rds[1][3] = 8'h00;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_scl", 64'(a_scl), 64'd1);
        check("rst_sda_out", 64'(a_sda_out), 64'd1);
        check("rst_sda_oe", 64'(a_sda_oe), 64'd1);
        check("rst_busy_done_nack", {a_busy, a_done, a_nack}, 64'd0);
        check("rst_rd_data", 64'(a_rdata), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // write with a START_STB re-asserted mid-transfer
        base_r = scl_rises[0]; base_d = done_cnt[0]; base_s = starts[0];
        start_a(7'h1A, 1'b0, 16'hAAAD);
        repeat (100) @(negedge clk);
        a_stb = 1'b1; a_wdata = 16'h1234;
        @(negedge clk);
        a_stb = 1'b0;
        wait_done(0, "wr");
        check("wr_nack", 64'(a_nack), 64'd0);
        @(negedge clk);
        check("wr_done_one_cycle", 64'(a_done), 64'd0);
        repeat (40) @(negedge clk);
        check("wr_addr_byte", 64'(addr_seen[0]), 64'h34);
        check("wr_byte0", 64'(got[0][0]), 64'hAA);
        check("wr_byte1", 64'(got[0][1]), 64'hAD);
        check("wr_nbytes", 64'(got_n[0]), 64'd2);
        check("wr_scl_rises", 64'(scl_rises[0] - base_r), 64'd28);
        check("wr_busy_to_done", 64'(done_cyc[0] - busy_cyc[0]), 64'((11 + 9 * 2) * 16));
        check("wr_single_done", 64'(done_cnt[0] - base_d), 64'd1);
        check("wr_single_start", 64'(starts[0] - base_s), 64'd1);
        check("wr_rd_data_kept", 64'(a_rdata), 64'd0);
        $display("txn write 1A AAAD: slave got %h %h", got[0][0], got[0][1]);

        // read
        base_r = scl_rises[0];
        start_a(7'h1A, 1'b1, 16'h0000);
        wait_done(0, "rd");
        check("rd_data_on_done", 64'(a_rdata), 64'hEEED);
        check("rd_nack", 64'(a_nack), 64'd0);
        repeat (40) @(negedge clk);
        check("rd_addr_byte", 64'(addr_seen[0]), 64'h35);
        check("rd_master_acks", 64'(mack[0][1:0]), 64'b10);
        check("rd_scl_rises", 64'(scl_rises[0] - base_r), 64'd28);
        $display("txn read 1A: rd_data %h", a_rdata);

        // address NACK on a read, then a back-to-back write
        present[0] = 1'b0;
        base_r = scl_rises[0];
        start_a(7'h1A, 1'b1, 16'h0000);
        wait_done(0, "anack");
        check("anack_nack", 64'(a_nack), 64'd1);
        check("anack_rd_data_kept", 64'(a_rdata), 64'hEEED);
        check("anack_scl_rises", 64'(scl_rises[0] - base_r), 64'd10);
        check("anack_no_data", 64'(got_n[0]), 64'd0);
        present[0] = 1'b1;
        a_addr = 7'h1A; a_rnw = 1'b0; a_wdata = 16'hEABD; a_stb = 1'b1;
        @(negedge clk);
        a_stb = 1'b0;
        check("anack_busy_to_done", 64'(done_cyc[0] - busy_cyc[0]), 64'((1 + 9 + 1) * 16));
        check("b2b_nack_cleared", 64'(a_nack), 64'd0);
        check("b2b_busy", 64'(a_busy), 64'd1);
        $display("txn addr-nack read 1A: nack_err set, rd_data %h", a_rdata);
        wait_done(0, "b2b");
        check("b2b_nack", 64'(a_nack), 64'd0);
        repeat (40) @(negedge clk);
        check("b2b_bytes", {got[0][0], got[0][1]}, 64'hEABD);
        $display("txn back-to-back write 1A EABD: slave got %h %h", got[0][0], got[0][1]);

        // NACK on the first data byte
        nack_byte[0] = 0;
        base_r = scl_rises[0];
        start_a(7'h1A, 1'b0, 16'h5566);
        wait_done(0, "dnack");
        check("dnack_nack", 64'(a_nack), 64'd1);
        repeat (40) @(negedge clk);
        check("dnack_scl_rises", 64'(scl_rises[0] - base_r), 64'd19);
        check("dnack_nbytes", 64'(got_n[0]), 64'd1);
        check("dnack_busy_to_done", 64'(done_cyc[0] - busy_cyc[0]), 64'((1 + 9 + 9 + 1) * 16));
        check("dnack_rd_data_kept", 64'(a_rdata), 64'hEEED);
        nack_byte[0] = -1;
        $display("txn write 1A 5566 with data nack: nack_err %b", a_nack);

        // reset in the middle of the first data byte
        base_d = done_cnt[0];
        start_a(7'h1A, 1'b0, 16'h1357);
        repeat (200) @(negedge clk);
        check("mid_busy", 64'(a_busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_lines", {a_scl, a_sda_out, a_sda_oe}, 64'b111);
        check("mid_rst_busy_done", {a_busy, a_done}, 64'd0);
        check("mid_rst_rd_data", 64'(a_rdata), 64'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_rst_no_done", 64'(done_cnt[0] - base_d), 64'd0);
        $display("txn write 1A 1357 cut by reset");

        // 4-byte, CLK_DIV=1 build
        base_r = scl_rises[1];
        @(negedge clk);
        b_addr = 7'h50; b_rnw = 1'b0; b_wdata = 32'hDEADBEEF; b_stb = 1'b1;
        @(negedge clk);
        b_stb = 1'b0;
        wait_done(1, "b_wr");
        check("b_nack", 64'(b_nack), 64'd0);
        repeat (10) @(negedge clk);
        check("b_addr_byte", 64'(addr_seen[1]), 64'hA0);
        check("b_bytes", {got[1][0], got[1][1], got[1][2], got[1][3]}, 64'hDEADBEEF);
        check("b_scl_rises", 64'(scl_rises[1] - base_r), 64'd46);
        check("b_busy_to_done", 64'(done_cyc[1] - busy_cyc[1]), 64'((11 + 9 * 4) * 4));
        check("b_rd_data_kept", 64'(b_rdata), 64'd0);
        $display("txn 4-byte write 50 DEADBEEF: slave got %h %h %h %h",
                 got[1][0], got[1][1], got[1][2], got[1][3]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
